// File: rtl/alu_exec_stage_pkg.sv
// Shared opcode constants, ALU select codes and decode control bundle for the
// LC-3b operate-instruction execute stage.
package alu_exec_stage_pkg;

    localparam logic [3:0] OPC_ADD = 4'b0001;
    localparam logic [3:0] OPC_AND = 4'b0101;
    localparam logic [3:0] OPC_XOR = 4'b1001;
    localparam logic [3:0] OPC_SHF = 4'b1101;

    localparam logic [2:0] NZP_RST = 3'b010;

    // Select codes understood by the external ALU mux.
    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_AND   = 3'd1,
        ALU_NOT   = 3'd2,
        ALU_XOR   = 3'd3,
        ALU_LSHF  = 3'd4,
        ALU_RSHFL = 3'd5,
        ALU_RSHFA = 3'd6,
        ALU_ZERO  = 3'd7
    } alu_op_e;

    typedef struct packed {
        alu_op_e    op;
        logic [3:0] shift;
        logic       use_imm;
        logic       uses_sr2;
        logic       illegal;
    } dec_ctl_t;

    function automatic logic [2:0] nzp_of(input logic msb, input logic is_zero);
        return msb ? 3'b100 : (is_zero ? 3'b010 : 3'b001);
    endfunction

endpackage

// File: rtl/alu_exec_stage_decode.sv
// Combinational decode of an LC-3b operate word into ALU controls, register
// fields and the sign-extended imm5.
module alu_exec_stage_decode
    import alu_exec_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3
) (
    input  logic [15:0]       instr,
    output dec_ctl_t          ctl,
    output logic [DATA_W-1:0] imm_sext,
    output logic [RA_W-1:0]   dr,
    output logic [RA_W-1:0]   sr1,
    output logic [RA_W-1:0]   sr2
);

    assign imm_sext = {{(DATA_W-5){instr[4]}}, instr[4:0]};
    assign dr       = instr[11:9];
    assign sr1      = instr[8:6];
    assign sr2      = instr[2:0];

    always_comb begin
        ctl = '{op: ALU_ZERO, shift: instr[3:0], use_imm: instr[5],
                uses_sr2: 1'b0, illegal: 1'b0};
        case (instr[15:12])
            OPC_ADD: begin
                ctl.op       = ALU_ADD;
                ctl.uses_sr2 = !instr[5];
            end
            OPC_AND: begin
                ctl.op       = ALU_AND;
                ctl.uses_sr2 = !instr[5];
            end
            OPC_XOR: begin
                // XOR with an all-ones immediate is the architectural NOT.
                ctl.op       = (instr[5] && instr[4:0] == 5'b11111) ? ALU_NOT : ALU_XOR;
                ctl.uses_sr2 = !instr[5];
            end
            OPC_SHF: begin
                ctl.use_imm = 1'b1;
                case (instr[5:4])
                    2'b00:   ctl.op = ALU_LSHF;
                    2'b01:   ctl.op = ALU_RSHFL;
                    2'b11:   ctl.op = ALU_RSHFA;
                    default: ctl.illegal = 1'b1;
                endcase
            end
            default: ctl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-entry execute stage: S1 holds the registered ALU operands, S2 holds the
// captured result awaiting register-file writeback. RAW interlock + forwarding.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic [RA_W-1:0]   rf_sr1,
    output logic [RA_W-1:0]   rf_sr2,
    input  logic [DATA_W-1:0] rf_sr1_data,
    input  logic [DATA_W-1:0] rf_sr2_data,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [2:0]        alu_op,
    output logic [3:0]        alu_shift,
    input  logic [DATA_W-1:0] alu_out,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [RA_W-1:0]   wb_dr,
    output logic [DATA_W-1:0] wb_data,
    output logic [2:0]        cc_nzp,
    output logic              illegal
);

    dec_ctl_t          ctl;
    logic [DATA_W-1:0] imm_sext;
    logic [RA_W-1:0]   dr, sr1, sr2;

    alu_exec_stage_decode #(.DATA_W(DATA_W), .RA_W(RA_W)) u_dec (
        .instr    (in_instr),
        .ctl      (ctl),
        .imm_sext (imm_sext),
        .dr       (dr),
        .sr1      (sr1),
        .sr2      (sr2)
    );

    assign rf_sr1 = sr1;
    assign rf_sr2 = sr2;

    logic            s1_v;
    logic [RA_W-1:0] s1_dr;
    logic            s2_adv, s1_adv;
    logic            hit1_s1, hit2_s1, hit1_s2, hit2_s2, hazard, accept;
    logic [DATA_W-1:0] op1, op2;

    // wb_valid doubles as the S2 valid bit.
    assign s2_adv = !wb_valid || wb_ready;
    assign s1_adv = s1_v && s2_adv;

    assign hit1_s1 = s1_v && (sr1 == s1_dr);
    assign hit2_s1 = s1_v && ctl.uses_sr2 && (sr2 == s1_dr);
    assign hit1_s2 = wb_valid && (sr1 == wb_dr);
    assign hit2_s2 = wb_valid && ctl.uses_sr2 && (sr2 == wb_dr);

    // S1 result is not yet computed, so an S1 match always stalls; an S2 match
    // is either bypassed from wb_data or stalled when forwarding is disabled.
    assign hazard   = !ctl.illegal &&
                      (hit1_s1 || hit2_s1 || (!FWD_EN && (hit1_s2 || hit2_s2)));
    assign in_ready = (!s1_v || s1_adv) && !hazard;
    assign accept   = in_valid && in_ready;

    assign op1 = (FWD_EN && hit1_s2) ? wb_data : rf_sr1_data;
    assign op2 = ctl.use_imm           ? imm_sext :
                 (FWD_EN && hit2_s2)   ? wb_data  : rf_sr2_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_v      <= 1'b0;
            s1_dr     <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_op    <= ALU_ZERO;
            alu_shift <= '0;
            wb_valid  <= 1'b0;
            wb_dr     <= '0;
            wb_data   <= '0;
            cc_nzp    <= NZP_RST;
            illegal   <= 1'b0;
        end else begin
            illegal <= accept && ctl.illegal;

            if (accept && !ctl.illegal) begin
                s1_v      <= 1'b1;
                s1_dr     <= dr;
                alu_in1   <= op1;
                alu_in2   <= op2;
                alu_op    <= ctl.op;
                alu_shift <= ctl.shift;
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end

            if (s2_adv) begin
                wb_valid <= s1_v;
                if (s1_v) begin
                    wb_data <= alu_out;
                    wb_dr   <= s1_dr;
                end
            end

            if (wb_valid && wb_ready)
                cc_nzp <= nzp_of(wb_data[DATA_W-1], wb_data == '0);
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: behavioural ALU and register file around the DUT,
// with an in-order architectural reference model predicting every writeback.
module tb_alu_exec_stage;

    localparam bit FWD_EN = 1'b1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [15:0] in_instr;
    logic [2:0]  rf_sr1, rf_sr2;
    logic [15:0] rf_sr1_data, rf_sr2_data;
    logic [15:0] alu_in1, alu_in2, alu_out;
    logic [2:0]  alu_op;
    logic [3:0]  alu_shift;
    logic        wb_valid, wb_ready;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic [2:0]  cc_nzp;
    logic        illegal;

    always #5 clk = ~clk;

    alu_exec_stage #(.DATA_W(16), .RA_W(3), .FWD_EN(FWD_EN)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
        .rf_sr1_data(rf_sr1_data), .rf_sr2_data(rf_sr2_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_shift(alu_shift),
        .alu_out(alu_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dr(wb_dr), .wb_data(wb_data),
        .cc_nzp(cc_nzp), .illegal(illegal)
    );

    // Environment: register file and ALU
    logic [15:0] rf [8];
    assign rf_sr1_data = rf[rf_sr1];
    assign rf_sr2_data = rf[rf_sr2];

    always_comb begin
        case (alu_op)
            3'd0:    alu_out = alu_in1 + alu_in2;
            3'd1:    alu_out = alu_in1 & alu_in2;
            3'd2:    alu_out = ~alu_in1;
            3'd3:    alu_out = alu_in1 ^ alu_in2;
            3'd4:    alu_out = alu_in1 << alu_shift;
            3'd5:    alu_out = alu_in1 >> alu_shift;
            3'd6:    alu_out = $signed(alu_in1) >>> alu_shift;
            default: alu_out = 16'h0000;
        endcase
    end

    // Reference model: architectural registers in program order
    typedef struct packed { logic [2:0] dr; logic [15:0] data; } wb_t;
    wb_t         q[$];
    logic [15:0] m_reg [8];
    logic [2:0]  m_cc;
    logic        exp_ill;
    logic        last_acc;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] ref_nzp(input logic [15:0] d);
        if (d[15])      return 3'b100;
        else if (d == 0) return 3'b010;
        else            return 3'b001;
    endfunction

    task automatic sync_model();
        for (int r = 0; r < 8; r++) m_reg[r] = rf[r];
        q.delete();
        m_cc    = 3'b010;
        exp_ill = 1'b0;
    endtask

    task automatic set_reg(input int r, input logic [15:0] v);
        rf[r]    = v;
        m_reg[r] = v;
    endtask

    // Architectural execution of one accepted word.
    task automatic model_exec(input logic [15:0] ins);
        logic [15:0] a, b, r;
        logic        legal;
        a = m_reg[ins[8:6]];
        b = ins[5] ? {{11{ins[4]}}, ins[4:0]} : m_reg[ins[2:0]];
        r = 16'h0000;
        legal = 1'b1;
        case (ins[15:12])
            4'd1:  r = a + b;
            4'd5:  r = a & b;
            4'd9:  r = a ^ b;
            4'd13: case (ins[5:4])
                       2'd0:    r = a << ins[3:0];
                       2'd1:    r = a >> ins[3:0];
                       2'd3:    r = $signed(a) >>> ins[3:0];
                       default: legal = 1'b0;
                   endcase
            default: legal = 1'b0;
        endcase
        if (legal) begin
            m_reg[ins[11:9]] = r;
            q.push_back('{dr: ins[11:9], data: r});
        end
        exp_ill = !legal;
    endtask

    // One clock: sample handshakes at negedge, update model after the edge.
    task automatic step();
        logic        acc, hs;
        logic [2:0]  hdr;
        logic [15:0] hdata, ins;
        wb_t         e;
        @(negedge clk);
        acc   = in_valid && in_ready;
        hs    = wb_valid && wb_ready;
        hdr   = wb_dr;
        hdata = wb_data;
        ins   = in_instr;
        @(posedge clk);
        #1;
        last_acc = acc;
        if (hs) begin
            rf[hdr] = hdata;
            chk("wb_expected", (q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("wb_dr", hdr, e.dr);
                chk("wb_data", hdata, e.data);
                m_cc = ref_nzp(e.data);
            end
        end
        if (acc) model_exec(ins);
        else     exp_ill = 1'b0;
        chk("illegal", illegal, exp_ill);
        chk("cc_nzp", cc_nzp, m_cc);
    endtask

    task automatic issue(input logic [15:0] ins, output int stalls);
        in_valid = 1'b1;
        in_instr = ins;
        stalls   = 0;
        last_acc = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (last_acc) break;
            stalls++;
        end
        chk("issue_accept", last_acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        wb_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (q.size() == 0) break;
            step();
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_wbv", wb_valid, 0);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0]  opc;
        logic [11:0] low;
        low = 12'($urandom);
        case ($urandom % 6)
            0:       opc = 4'b0001;
            1:       opc = 4'b0101;
            2:       opc = 4'b1001;
            3:       opc = 4'b1101;
            default: opc = 4'($urandom);
        endcase
        return {opc, low};
    endfunction

    initial begin
        int          st, k;
        logic        have;
        logic [15:0] held;
        logic [15:0] bp [3];
        bp = '{16'h15A1, 16'h57A0, 16'h9BBE};

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        wb_ready = 1'b1;
        for (int r = 0; r < 8; r++) rf[r] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wbv", wb_valid, 0);
        chk("rst_cc", cc_nzp, 3'b010);
        chk("rst_op", alu_op, 3'd7);
        chk("rst_in1", alu_in1, 0);
        chk("rst_in2", alu_in2, 0);
        chk("rst_shift", alu_shift, 0);
        chk("rst_dr", wb_dr, 0);
        chk("rst_data", wb_data, 0);
        chk("rst_ill", illegal, 0);
        reset_n = 1'b1;
        sync_model();

        // ADD R1,R2,#-3 with R2=5
        set_reg(2, 16'd5);
        issue(16'h12BD, st);
        chk("add_op", alu_op, 3'd0);
        chk("add_in1", alu_in1, 16'd5);
        chk("add_in2", alu_in2, 16'hFFFD);
        chk("add_wbv_early", wb_valid, 0);
        step();
        chk("add_wbv", wb_valid, 1);
        chk("add_dr", wb_dr, 3'd1);
        chk("add_data", wb_data, 16'd2);
        step();
        chk("add_cc", cc_nzp, 3'b001);

        // RSHFA R3,R4,#4 with R4=8000, then XOR R5,R4,#-1 with R4=0
        set_reg(4, 16'h8000);
        issue(16'hD734, st);
        chk("shf_op", alu_op, 3'd6);
        set_reg(4, 16'h0000);
        issue(16'h9B3F, st);
        chk("xor_op", alu_op, 3'd2);
        chk("shf_data", wb_data, 16'hF800);
        step();
        chk("shf_cc", cc_nzp, 3'b100);
        chk("xor_data", wb_data, 16'hFFFF);
        step();

        // RAW chain ADD R1,R1,#1 x3 from R1=0
        set_reg(1, 16'h0000);
        issue(16'h1261, st);
        chk("raw_st0", st, 0);
        issue(16'h1261, st);
        chk("raw_st1", st, FWD_EN ? 1 : 2);
        issue(16'h1261, st);
        chk("raw_st2", st, FWD_EN ? 1 : 2);
        drain();
        chk("raw_r1", rf[1], 16'd3);

        // Backpressure: 5 cycles of wb_ready=0 with three words offered
        set_reg(6, 16'd7);
        wb_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = bp[0];
        k = 0;
        have = 1'b0;
        held = 16'h0000;
        for (int c = 0; c < 5; c++) begin
            step();
            if (last_acc) begin
                k++;
                if (k < 3) in_instr = bp[k];
            end
            if (wb_valid) begin
                if (have) chk("bp_hold", wb_data, held);
                else begin
                    have = 1'b1;
                    held = wb_data;
                end
            end
        end
        chk("bp_accepted", k, 2);
        wb_ready = 1'b1;
        for (int c = 0; c < 10 && k < 3; c++) begin
            step();
            if (last_acc) k++;
        end
        chk("bp_all", k, 3);
        drain();
        chk("bp_cc", cc_nzp, 3'b100);
        chk("bp_r2", rf[2], 16'd8);

        // Illegal words
        issue(16'h0E3F, st);
        chk("ill0_pulse", illegal, 1);
        step();
        chk("ill0_clear", illegal, 0);
        chk("ill0_wbv", wb_valid, 0);
        issue(16'hD020, st);
        chk("ill1_pulse", illegal, 1);
        step();
        chk("ill1_clear", illegal, 0);
        chk("ill1_wbv", wb_valid, 0);
        chk("ill_cc", cc_nzp, 3'b100);

        // Reset with S1 and S2 both occupied
        wb_ready = 1'b0;
        issue(16'h15A1, st);
        issue(16'h57A0, st);
        chk("mid_wbv_full", wb_valid, 1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_wbv", wb_valid, 0);
        chk("mid_rst_cc", cc_nzp, 3'b010);
        chk("mid_rst_op", alu_op, 3'd7);
        reset_n  = 1'b1;
        wb_ready = 1'b1;
        sync_model();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("mid_dropped", wb_valid, 0);
        end

        // Randomized traffic
        for (int r = 0; r < 8; r++) rf[r] = 16'($urandom);
        sync_model();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom % 4) != 0;
            in_instr = rand_instr();
            wb_ready = ($urandom % 4) != 0;
            step();
        end
        drain();
        for (int r = 0; r < 8; r++) chk("final_reg", rf[r], m_reg[r]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
